// File: rtl/float_pkg.sv
// ----------------------------------------------------------------------------
// float_pkg
// Shared types and constants for the floating-point stimulus blocks.
//   rand_mode_e  : sample shaping mode of float_rand_gen (encoding 3 is
//                  reserved and treated as RAND_RAW by the generator)
//   LFSR64_TAPS  : Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1
//   float_t      : single-precision layout (EXP_W = 8, MAN_W = 23)
//   lfsr64_step  : one right-shifting Galois step of the 64-bit LFSR
// ----------------------------------------------------------------------------
package float_pkg;

    typedef enum logic [1:0] {
        RAND_RAW       = 2'd0,
        RAND_BOUNDED   = 2'd1,
        RAND_ZERO_ONLY = 2'd2
    } rand_mode_e;

    // Right-shift Galois form: polynomial term x^k maps to mask bit k-1.
    localparam logic [63:0] LFSR64_TAPS = 64'hD800_0000_0000_0000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    function automatic logic [63:0] lfsr64_step(input logic [63:0] s);
        return {1'b0, s[63:1]} ^ (s[0] ? LFSR64_TAPS : 64'd0);
    endfunction

endpackage

// File: rtl/lfsr64.sv
// ----------------------------------------------------------------------------
// lfsr64
// 64-bit Galois LFSR that advances on every clock outside reset. A load
// replaces the step for that cycle; a zero seed (parameter or load value)
// is replaced by 64'h1 so the register never locks up in the all-zero state.
// Ports:
//   clk      : clock
//   rst      : synchronous, active-high reset (state <- SEED, or 1 if SEED=0)
//   load     : take load_val on the next edge instead of stepping
//   load_val : seed to load
//   state    : current LFSR state
// ----------------------------------------------------------------------------
module lfsr64
    import float_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] load_val,
    output logic [63:0] state
);

    localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;

    logic [63:0] state_q;
    logic [63:0] state_d;

    always_comb begin
        if (load) begin
            state_d = (load_val == 64'd0) ? 64'd1 : load_val;
        end else begin
            state_d = lfsr64_step(state_q);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/float_rand_gen.sv
// ----------------------------------------------------------------------------
// float_rand_gen
// Pseudo-random floating-point sample source behind a valid/ready handshake.
// Each loaded sample is the low 1+EXP_W+MAN_W bits of the LFSR, shaped by
// mode (RAW / BOUNDED exponent clamp / ZERO_ONLY), periodic signed-zero
// injection every ZERO_RATE-th load, and exponent-0 handling.
//
// Build option: define FLOAT_RAND_SUBNORM_EN to let subnormals through;
// otherwise exponent-0 samples have their mantissa cleared (flush-to-zero).
//
// Ports:
//   clk        : clock
//   rst        : synchronous, active-high reset
//   en         : generation enable
//   mode       : 0 RAW, 1 BOUNDED, 2 ZERO_ONLY, 3 reserved (RAW)
//   seed_load  : load seed_val into the LFSR, clear zero counter, no sample
//   seed_val   : seed to load (0 is replaced by 64'h1)
//   out_valid  : out_float holds a sample
//   out_ready  : consumer accepts the sample
//   out_float  : {sign, biased exponent, mantissa}
//   sample_cnt : accepted transfers since reset, wrapping at 2^32
// ----------------------------------------------------------------------------
module float_rand_gen
    import float_pkg::*;
#(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned MAN_W     = 23,
    parameter int unsigned ZERO_RATE = 10,
    parameter int unsigned MAX_POW   = 9,
    parameter logic [63:0] SEED      = 64'h1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic                   seed_load,
    input  logic [63:0]            seed_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_float,
    output logic [31:0]            sample_cnt
);

    localparam int unsigned FW       = 1 + EXP_W + MAN_W;
    localparam int unsigned ZC_W     = (ZERO_RATE > 1) ? $clog2(ZERO_RATE) : 1;
    localparam int unsigned BIAS     = (32'd1 << (EXP_W - 1)) - 32'd1;
    localparam int unsigned EXP_ALL1 = (32'd1 << EXP_W) - 32'd1;
    // Clamp target BIAS+MAX_POW; it stays finite as long as MAX_POW <= BIAS.
    localparam int unsigned LIM_INT  = (BIAS + MAX_POW < EXP_ALL1) ? (BIAS + MAX_POW) : EXP_ALL1;
    localparam logic [EXP_W-1:0] EXP_LIM = LIM_INT[EXP_W-1:0];

    logic [63:0] lfsr_state;
    // Only the low FW bits feed the sample; the rest are folded away here.
    logic        unused_lfsr;

    lfsr64 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed_val),
        .state    (lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state;

    logic              out_valid_q, out_valid_d;
    logic [FW-1:0]     out_float_q, out_float_d;
    logic [31:0]       sample_cnt_q, sample_cnt_d;
    logic [ZC_W-1:0]   zcnt_q, zcnt_d;

    logic              load;
    logic              xfer;
    logic              zero_hit;
    logic              sign_v;
    logic [EXP_W-1:0]  exp_v;
    logic [MAN_W-1:0]  man_v;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        xfer     = out_valid_q && out_ready;
        load     = en && !seed_load && (!out_valid_q || out_ready);
        zero_hit = (ZERO_RATE != 0) && (zcnt_q == ZC_W'(ZERO_RATE - 1));

        sign_v = lfsr_state[FW-1];
        exp_v  = lfsr_state[FW-2 -: EXP_W];
        man_v  = lfsr_state[MAN_W-1:0];

        case (mode)
            RAND_BOUNDED: begin
                if (exp_v > EXP_LIM) exp_v = EXP_LIM;
            end
            RAND_ZERO_ONLY: begin
                exp_v = '0;
                man_v = '0;
            end
            default: ;
        endcase

        // Injected zeros keep the raw sign so both +0 and -0 appear.
        if (zero_hit) begin
            exp_v = '0;
            man_v = '0;
        end

`ifdef FLOAT_RAND_SUBNORM_EN
        // Subnormals pass through unchanged.
`else
        if (exp_v == '0) man_v = '0;
`endif

        out_valid_d  = out_valid_q;
        out_float_d  = out_float_q;
        sample_cnt_d = sample_cnt_q;
        zcnt_d       = zcnt_q;

        if (xfer) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
            out_valid_d  = 1'b0;
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_float_d = {sign_v, exp_v, man_v};
            if (ZERO_RATE != 0) begin
                zcnt_d = zero_hit ? '0 : zcnt_q + 1'b1;
            end
        end

        // A reseed restarts the zero-injection phase along with the LFSR.
        if (seed_load) begin
            zcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_float_q  <= '0;
            sample_cnt_q <= '0;
            zcnt_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_float_q  <= out_float_d;
            sample_cnt_q <= sample_cnt_d;
            zcnt_q       <= zcnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_float  = out_float_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_float_rand_gen.sv
// ----------------------------------------------------------------------------
// tb_float_rand_gen
// Self-checking bench for float_rand_gen in its default build (subnormals
// flushed). A behavioural model tracks the LFSR as a number sequence, counts
// loads to place injected zeros, and shapes samples with integer arithmetic
// on the sign / exponent / mantissa fields.
// ----------------------------------------------------------------------------
module tb_float_rand_gen;

    localparam int          EXP_W     = 8;
    localparam int          MAN_W     = 23;
    localparam int          FW        = 32;
    localparam int          ZERO_RATE = 10;
    localparam int          MAX_POW   = 9;
    localparam int unsigned BIAS      = 127;
    localparam int unsigned P23       = 32'h0080_0000;
    localparam int unsigned P31       = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          seed_load;
    logic [63:0]   seed_val;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_float;
    logic [31:0]   sample_cnt;

    float_rand_gen #(
        .EXP_W     (EXP_W),
        .MAN_W     (MAN_W),
        .ZERO_RATE (ZERO_RATE),
        .MAX_POW   (MAX_POW),
        .SEED      (64'h1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed_val   (seed_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_float  (out_float),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0]  m_lfsr;
    bit           m_valid;
    logic [31:0]  m_float;
    int unsigned  m_cnt;
    int unsigned  m_loads;   // loads since reset / reseed

    // Multiplication by x^-1 modulo x^64+x^63+x^61+x^60+1 in right-shift form.
    function automatic logic [63:0] next_lfsr(input logic [63:0] s);
        logic [63:0] poly_hi;
        poly_hi = 64'hD800_0000_0000_0000;
        if (s[0]) return (s >> 1) ^ poly_hi;
        return s >> 1;
    endfunction

    function automatic logic [31:0] model_shape(input logic [63:0] st, input int md, input bit zero);
        int unsigned raw, s, e, m;
        raw = st[31:0];
        s   = raw / P31;
        e   = (raw / P23) % 256;
        m   = raw % P23;
        if (md == 1 && e > BIAS + MAX_POW) e = BIAS + MAX_POW;
        if (md == 2 || zero) begin
            e = 0;
            m = 0;
        end
        if (e == 0) m = 0;
        return s * P31 + e * P23 + m;
    endfunction

    task automatic model_step();
        bit ld, zero;
        if (rst) begin
            m_lfsr  = 64'h1;
            m_valid = 0;
            m_float = '0;
            m_cnt   = 0;
            m_loads = 0;
            return;
        end
        ld = en && !seed_load && (!m_valid || out_ready);
        if (m_valid && out_ready) begin
            m_cnt++;
            m_valid = 0;
        end
        if (ld) begin
            zero    = ((m_loads + 1) % ZERO_RATE) == 0;
            m_float = model_shape(m_lfsr, int'(mode), zero);
            m_loads++;
            m_valid = 1;
        end
        if (seed_load) begin
            m_lfsr  = (seed_val == 64'd0) ? 64'h1 : seed_val;
            m_loads = 0;
        end else begin
            m_lfsr = next_lfsr(m_lfsr);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("valid", {63'd0, out_valid}, {63'd0, m_valid});
        check("float", {32'd0, out_float}, {32'd0, m_float});
        check("cnt", {32'd0, sample_cnt}, {32'd0, m_cnt});
        check("lfsr", dut.lfsr_state, m_lfsr);
    endtask

    task automatic set_in(input bit r, input bit e, input logic [1:0] md, input bit sl,
                          input logic [63:0] sv, input bit rdy);
        rst = r; en = e; mode = md; seed_load = sl; seed_val = sv; out_ready = rdy;
    endtask

    typedef struct {
        bit          rst;
        bit          en;
        bit          seed_load;
        bit          ready;
        logic [1:0]  mode;
        logic [63:0] seed;
        bit          exp_valid;
        int unsigned exp_cnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [FW-1:0] hold_f;
        logic [31:0]   hold_c;

        // rst, en, seed_load, ready, mode, seed, exp_valid, exp_cnt
        vecs[0]  = '{1, 0, 0, 0, 2'd0, 64'd0, 0, 0};  // reset
        vecs[1]  = '{0, 1, 0, 1, 2'd0, 64'd0, 1, 0};  // first load
        vecs[2]  = '{0, 1, 0, 0, 2'd0, 64'd0, 1, 0};  // stall, hold
        vecs[3]  = '{0, 0, 0, 0, 2'd0, 64'd0, 1, 0};  // en low keeps valid
        vecs[4]  = '{0, 0, 0, 1, 2'd0, 64'd0, 0, 1};  // transfer, no reload
        vecs[5]  = '{0, 0, 0, 1, 2'd0, 64'd0, 0, 1};  // idle
        vecs[6]  = '{0, 1, 0, 0, 2'd1, 64'd0, 1, 1};  // load while not ready
        vecs[7]  = '{0, 1, 1, 1, 2'd0, 64'h1234_5678_9ABC_DEF0, 0, 2};  // seed + xfer
        vecs[8]  = '{0, 1, 1, 0, 2'd0, 64'd0, 0, 2};  // seed blocks load
        vecs[9]  = '{0, 1, 0, 0, 2'd2, 64'd0, 1, 2};  // zero-only load
        vecs[10] = '{0, 1, 1, 0, 2'd0, 64'd5, 1, 2};  // seed keeps pending
        vecs[11] = '{1, 1, 0, 1, 2'd0, 64'd0, 0, 0};  // reset drops pending

        set_in(1, 0, 2'd0, 0, 64'd0, 0);
        @(negedge clk);

        // ---- directed handshake table ----
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].seed_load,
                   vecs[i].seed, vecs[i].ready);
            cycle();
            check($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
            check($sformatf("tbl%0d_cnt", i), {32'd0, sample_cnt}, {32'd0, vecs[i].exp_cnt});
        end

        // ---- reset, RAW, 100 cycles at full throughput ----
        set_in(1, 0, 2'd0, 0, 64'd0, 0);
        cycle();
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_float", {32'd0, out_float}, 64'd0);
        set_in(0, 1, 2'd0, 0, 64'd0, 1);
        for (int k = 1; k <= 100; k++) begin
            cycle();
            if (k == 1) check("first_valid", {63'd0, out_valid}, 64'd1);
            if (k % ZERO_RATE == 0)
                check($sformatf("zero_inj%0d", k), {33'd0, out_float[30:0]}, 64'd0);
        end
        check("cnt99", {32'd0, sample_cnt}, 64'd99);

        // ---- out_ready low for 5 cycles mid-stream ----
        hold_f = out_float;
        hold_c = sample_cnt;
        out_ready = 0;
        cycle();                      // the pending sample is the one being held
        hold_f = out_float;
        hold_c = sample_cnt;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_float", {32'd0, out_float}, {32'd0, hold_f});
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_cnt", {32'd0, sample_cnt}, {32'd0, hold_c});
        end
        out_ready = 1;
        for (int k = 0; k < 5; k++) cycle();

        // ---- seed_load with zero seed ----
        set_in(0, 1, 2'd0, 1, 64'd0, 1);
        cycle();
        check("seed0_lfsr", dut.lfsr_state, 64'h1);
        check("seed0_novalid", {63'd0, out_valid}, 64'd0);
        set_in(0, 1, 2'd0, 0, 64'd0, 1);
        cycle();
        // Seed 1 gives raw 0x00000001: exponent 0, so the mantissa is flushed.
        check("seed0_sample", {32'd0, out_float}, 64'd0);
        cycle();
        check("seed0_sample2", {32'd0, out_float},
              {32'd0, model_shape(next_lfsr(64'h1), 0, 0)});

        // ---- reset during a pending valid ----
        set_in(0, 1, 2'd0, 0, 64'd0, 0);
        cycle();
        set_in(1, 1, 2'd0, 0, 64'd0, 0);
        cycle();
        check("rst_pend_valid", {63'd0, out_valid}, 64'd0);
        check("rst_pend_cnt", {32'd0, sample_cnt}, 64'd0);

        // ---- BOUNDED, 1000 cycles with random back-pressure ----
        set_in(0, 1, 2'd1, 0, 64'd0, 1);
        for (int k = 0; k < 1000; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (out_valid)
                check("bounded_exp",
                      {63'd0, (out_float[30:23] <= 8'd136) && (out_float[30:23] != 8'hFF)}, 64'd1);
        end

        // ---- RAW, 10000 transfers: exponent 0 always carries mantissa 0 ----
        set_in(0, 1, 2'd0, 0, 64'd0, 1);
        for (int k = 0; k < 10000; k++) begin
            cycle();
            if (out_float[30:23] == 8'd0)
                check("flush", {41'd0, out_float[22:0]}, 64'd0);
        end

        // ---- randomized mix of modes, stalls, reseeds and resets ----
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 4) != 0);
            mode      = 2'($urandom_range(0, 3));
            seed_load = ($urandom_range(0, 49) == 0);
            seed_val  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
